// File: rtl/mips32_pkg.sv
// Shared constants and the register-dump FSM state type for the pipe_mips32
// core, its program loader and the post-halt register dump block.
package mips32_pkg;

  localparam int MIPS32_NREGS  = 32;
  localparam int MIPS32_DATA_W = 32;
  localparam int MIPS32_IDX_W  = 5;

  // Register-dump walker states: read address presented (RD), read data
  // arriving (WT), word offered on the stream (SEND), dump complete (DONE).
  typedef enum logic [2:0] {
    IDLE,
    RD,
    WT,
    SEND,
    DONE
  } state_t;

endpackage

// File: rtl/mips32_regdump_if.sv
// Indexed-word valid/ready stream carrying one register per transfer.
interface mips32_regdump_if
  import mips32_pkg::*;
#(
  parameter int DATA_W = MIPS32_DATA_W,
  parameter int IDX_W  = MIPS32_IDX_W
) ();

  logic              valid;
  logic              ready;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] data;
  logic              last;

  // Source side: the register dump block.
  modport master (
    output valid,
    output idx,
    output data,
    output last,
    input  ready
  );

  // Sink side: bench, debug UART bridge.
  modport slave (
    input  valid,
    input  idx,
    input  data,
    input  last,
    output ready
  );

endinterface

// File: rtl/mips32_regdump.sv
// Post-halt register-file reader: on a rising edge of halted, walks the
// general register file through its 1-cycle synchronous read port and emits
// every register as {idx, data, last} on a valid/ready stream.
module mips32_regdump
  import mips32_pkg::*;
#(
  parameter int NREGS  = MIPS32_NREGS,
  parameter int DATA_W = MIPS32_DATA_W,
  parameter int IDX_W  = MIPS32_IDX_W
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              halted,
  output logic [IDX_W-1:0]  rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  mips32_regdump_if.master  dout,
  output logic              busy,
  output logic              done
);

  // Terminal index decoded explicitly so NREGS need not be a power of two.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

  state_t            state;
  logic              halted_q;
  logic              armed;
  logic [IDX_W-1:0]  idx;
  logic              valid_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;

  logic start;

  // A dump starts only on a genuine low-to-high transition of halted. The
  // armed flag keeps the first post-reset cycle from reading a reset-cleared
  // halted_q as "was low", so a level already high at reset release is
  // treated as old news.
  assign start = halted && !halted_q && armed;

  // Halt-edge tracker: halted_q follows halted every cycle.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
      armed    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register here and below samples the
      // pre-edge value of its neighbours, independent of statement order.
      halted_q <= halted;
      armed    <= 1'b1;
    end
  end

  // Dump FSM: address, index counter and registered stream outputs.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rf_raddr <= '0;
      idx      <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rf_raddr <= '0;
            idx      <= '0;
            busy     <= 1'b1;
            state    <= RD;
          end
        end

        // Read address is stable this cycle; the register file samples it.
        RD: state <= WT;

        // Read data is valid now; capture it as the outgoing word.
        WT: begin
          data_q  <= rf_rdata;
          idx_q   <= idx;
          last_q  <= (idx == LAST_IDX);
          valid_q <= 1'b1;
          state   <= SEND;
        end

        // Word held unchanged until the sink takes it.
        SEND: begin
          if (dout.ready) begin
            valid_q <= 1'b0;
            if (last_q) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx      <= idx + 1'b1;
              rf_raddr <= idx + 1'b1;
              state    <= RD;
            end
          end
        end

        // done is held until the core leaves halt, which re-arms the block.
        DONE: begin
          if (!halted) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign dout.valid = valid_q;
  assign dout.idx   = idx_q;
  assign dout.data  = data_q;
  assign dout.last  = last_q;

endmodule

// File: tb/tb_mips32_regdump.sv
// Bench for mips32_regdump: a behavioural register file with 1-cycle read,
// a table of register contents with the expected dump words, and a stream
// monitor comparing every handshake and the dump timing against a model.
module tb_mips32_regdump;
  import mips32_pkg::*;

  localparam int NREGS = MIPS32_NREGS;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] rf_val;
    logic [31:0] exp_data;
    logic        exp_last;
  } vec_t;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        halted;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        busy;
  logic        done;

  logic [31:0] rf_mem [NREGS];
  vec_t        tbl [NREGS];

  int n_checks = 0;
  int n_fail   = 0;

  mips32_regdump_if #(.DATA_W(32), .IDX_W(5)) dif ();

  mips32_regdump dut (
    .clk1     (clk1),
    .rst_n    (rst_n),
    .halted   (halted),
    .rf_raddr (rf_raddr),
    .rf_rdata (rf_rdata),
    .dout     (dif.master),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk1 = ~clk1;

  // Register file with a 1-cycle synchronous read port.
  always @(posedge clk1) rf_rdata <= rf_mem[rf_raddr];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register contents after the add program, with Rk=k forced beforehand.
  task automatic load_program_table();
    tbl[0] = '{5'd0, 32'd0,  32'd0,  1'b0};
    tbl[1] = '{5'd1, 32'd10, 32'd10, 1'b0};
    tbl[2] = '{5'd2, 32'd20, 32'd20, 1'b0};
    tbl[3] = '{5'd3, 32'd25, 32'd25, 1'b0};
    tbl[4] = '{5'd4, 32'd30, 32'd30, 1'b0};
    tbl[5] = '{5'd5, 32'd55, 32'd55, 1'b0};
    for (int k = 6; k < NREGS; k++)
      tbl[k] = '{5'(k), 32'(k), 32'(k), (k == NREGS - 1)};
    for (int k = 0; k < NREGS; k++) rf_mem[k] = tbl[k].rf_val;
  endtask

  task automatic load_random_table();
    logic [31:0] v;
    for (int k = 0; k < NREGS; k++) begin
      v = $urandom;
      tbl[k] = '{5'(k), v, v, (k == NREGS - 1)};
      rf_mem[k] = v;
    end
  endtask

  task automatic cycle();
    @(posedge clk1);
    #1;
  endtask

  // mode: 0 = ready tied high, 1 = random ready, 2 = stall stall_len cycles
  // on stall_idx. pulse_idx >= 0 pulses halted low once on that word;
  // abort_idx >= 0 asserts reset while that word is stalled in SEND.
  task automatic run_dump(input int mode, input int stall_idx, input int stall_len,
                          input int pulse_idx, input int abort_idx);
    vec_t        exp_q [$];
    vec_t        e;
    int          n, stalls, hs_edge, stall_cnt;
    logic        prev_valid, prev_rdy, rdy, pulsed, restore, finished;
    logic [4:0]  p_idx;
    logic [31:0] p_data;
    logic        p_last;

    exp_q = {};
    for (int k = 0; k < NREGS; k++) exp_q.push_back(tbl[k]);
    n = 0; stalls = 0; hs_edge = 1; stall_cnt = 0;
    prev_valid = 1'b0; prev_rdy = 1'b1; pulsed = 1'b0; restore = 1'b0; finished = 1'b0;
    p_idx = '0; p_data = '0; p_last = 1'b0;

    halted = 1'b1;
    while (!finished && n < 3000) begin
      cycle();
      n++;
      if (restore) begin
        halted  = 1'b1;
        restore = 1'b0;
      end
      if (prev_valid && !prev_rdy)
        check("stall_hold", 64'({dif.valid, dif.idx, dif.data, dif.last}),
              64'({1'b1, p_idx, p_data, p_last}));
      if (dif.valid && !prev_valid)
        check("valid_rise_edge", 64'(n), 64'(hs_edge + 2));
      if (done) begin
        check("done_edge", 64'(n), 64'(97 + stalls));
        check("words_left", 64'(exp_q.size()), 64'(0));
        check("busy_falls", 64'(busy), 64'(0));
        finished = 1'b1;
      end else begin
        check("busy_during", 64'(busy), 64'(1));
        if (abort_idx >= 0 && dif.valid && dif.idx == 5'(abort_idx)) begin
          dif.ready = 1'b0;
          rst_n     = 1'b0;
          #1;
          check("reset_clears",
                64'({rf_raddr, dif.valid, dif.idx, dif.data, dif.last, busy, done}), 64'(0));
          finished = 1'b1;
        end else begin
          case (mode)
            1: rdy = 1'($urandom_range(0, 1));
            2: begin
              rdy = !(dif.valid && dif.idx == 5'(stall_idx) && stall_cnt < stall_len);
              if (!rdy) stall_cnt++;
            end
            default: rdy = 1'b1;
          endcase
          if (pulse_idx >= 0 && dif.valid && dif.idx == 5'(pulse_idx) && !pulsed) begin
            halted  = 1'b0;
            pulsed  = 1'b1;
            restore = 1'b1;
          end
          dif.ready = rdy;
          if (dif.valid && rdy) begin
            if (exp_q.size() == 0) begin
              check("extra_word", 64'(1), 64'(0));
            end else begin
              e = exp_q.pop_front();
              check("word_idx",  64'(dif.idx),  64'(e.idx));
              check("word_data", 64'(dif.data), 64'(e.exp_data));
              check("word_last", 64'(dif.last), 64'(e.exp_last));
            end
            hs_edge = n + 1;
          end
          if (dif.valid && !rdy) stalls++;
          prev_valid = dif.valid;
          prev_rdy   = rdy;
          p_idx      = dif.idx;
          p_data     = dif.data;
          p_last     = dif.last;
        end
      end
    end
    if (!finished) check("dump_timeout", 64'(0), 64'(1));
    if (mode == 2 && abort_idx < 0) check("stall_cycles", 64'(stall_cnt), 64'(stall_len));
  endtask

  // No stream activity for a number of cycles, with done at the given level.
  task automatic hold_quiet(input int cycles, input logic exp_done);
    for (int i = 0; i < cycles; i++) begin
      cycle();
      check("quiet_valid", 64'(dif.valid), 64'(0));
      check("quiet_done",  64'(done),      64'(exp_done));
      check("quiet_busy",  64'(busy),      64'(0));
    end
  endtask

  task automatic drop_halted();
    halted = 1'b0;
    cycle();
    check("done_clears", 64'(done),      64'(0));
    check("idle_valid",  64'(dif.valid), 64'(0));
    cycle();
  endtask

  initial begin
    rst_n     = 1'b0;
    halted    = 1'b0;
    dif.ready = 1'b0;
    load_program_table();
    repeat (3) @(posedge clk1);
    #1;
    check("reset_state",
          64'({rf_raddr, dif.valid, dif.idx, dif.data, dif.last, busy, done}), 64'(0));
    #4 rst_n = 1'b1;
    cycle();
    check("idle_after_reset", 64'({dif.valid, busy, done}), 64'(0));

    // Full dump with ready tied high; done held while halted stays high.
    run_dump(0, -1, 0, -1, -1);
    hold_quiet(5, 1'b1);
    drop_halted();

    // Random back-pressure.
    run_dump(1, -1, 0, -1, -1);
    drop_halted();

    // 20-cycle stall on R4.
    run_dump(2, 4, 20, -1, -1);
    drop_halted();

    // One-cycle halted glitch mid-dump must neither stop nor restart it.
    run_dump(0, -1, 0, 10, -1);
    hold_quiet(10, 1'b1);
    drop_halted();

    // Reset in SEND at idx 7; halted still high at release must not start.
    run_dump(0, -1, 0, -1, 7);
    #3 rst_n = 1'b1;
    hold_quiet(20, 1'b0);
    drop_halted();

    // Second dump after re-arming, random register contents and ready.
    load_random_table();
    run_dump(1, -1, 0, -1, -1);
    drop_halted();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips32_regdump.md
# mips32_regdump

Post-halt register-file reader for the pipe_mips32 core. When the core asserts HALTED, the block walks the 32-entry general register file through a synchronous read port. It emits every register as an indexed word on a valid/ready stream, with index, data and a last flag. Benches and the debug UART bridge use it to inspect program results without hierarchical references into the core.

## Interface
- NREGS, 32, number of registers dumped (indices 0..NREGS-1)
- DATA_W, 32, register width
- IDX_W, 5, index width; must satisfy 2**IDX_W >= NREGS

- clk1  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- halted  in  1  core HALTED flag, level
- rf_raddr  out  IDX_W  register-file read address
- rf_rdata  in  DATA_W  read data; valid in the cycle after rf_raddr is presented (1-cycle synchronous read)
- dout_valid  out  1  output word valid
- dout_ready  in  1  sink accepts word
- dout_idx  out  IDX_W  register index of the current word
- dout_data  out  DATA_W  register value
- dout_last  out  1  high with the word for index NREGS-1
- busy  out  1  dump in progress
- done  out  1  dump finished; held until halted falls

## Operation
- Reset values: rf_raddr=0, dout_valid=0, dout_idx=0, dout_data=0, dout_last=0, busy=0, done=0, FSM=IDLE, halted_q=0.
- Start condition is a halted rising edge: halted=1 && halted_q=0, where halted_q is registered every cycle.
- FSM states:
  - IDLE: wait for the start condition, then set rf_raddr<=0, idx<=0, busy<=1 and go to RD.
  - RD: rf_raddr is stable; go to WT unconditionally.
  - WT: rf_rdata is valid. Load dout_data<=rf_rdata, dout_idx<=idx, dout_last<=(idx==NREGS-1), dout_valid<=1. Go to SEND.
  - SEND: hold all dout_* until dout_valid && dout_ready.
    - On handshake with last=0: dout_valid<=0, idx<=idx+1, rf_raddr<=idx+1, go to RD.
    - On handshake with last=1: dout_valid<=0, busy<=0, done<=1, go to DONE.
  - DONE: when halted=0, clear done and go to IDLE.
- Stream rules:
  - dout_* must not change while dout_valid=1 and dout_ready=0.
  - dout_valid never drops without a handshake, except on reset.
- halted is ignored in RD, WT and SEND; a dump always completes once started.
- A new dump requires halted to fall (DONE→IDLE) and rise again.
- halted already high when reset is released produces no dump, because halted_q is sampled first.
- idx never wraps. The terminal index NREGS-1 is decoded explicitly, so non-power-of-two NREGS is supported.

## Timing
- Start-detect edge E0. rf_raddr=0 is present during the RD cycle after E0. dout_valid rises at E0+2 edges.
- With dout_ready tied high, each word takes 3 cycles (RD, WT, SEND). A full 32-register dump takes 96 cycles from E0 to done.
- done rises on the edge of the last handshake. busy falls on the same edge.
- Back-pressure adds exactly one cycle per cycle that dout_ready is low in SEND.
- Asserting rst_n low at any point, including mid-SEND, clears all outputs to reset values asynchronously. The partial dump is discarded.

## Structure
- mips32_pkg: the state enum (IDLE, RD, WT, SEND, DONE), MIPS32_NREGS=32, MIPS32_DATA_W=32, MIPS32_IDX_W=5. These are shared with pipe_mips32 and the program loader.
- No sub-module is warranted: one FSM, one index counter and the output registers, in a single module.

## Test plan
- Load the add program and run to HLT. Expect R0=0, R1=10, R2=20, R3=25, R4=30, R5=55, and Rk=k for k=6..30; R31 is unknown, so force Rk=k for k=0..31 before the program runs. With ready=1, expect 32 words, idx 0..31 in order, last only on idx 31, and done 96 cycles after the halted edge.
- Toggle dout_ready randomly (50%) during the dump. dout_* must stay stable while stalled, with no drops or duplicates; the sequence of values must match the scenario above.
- Hold dout_ready=0 for 20 cycles on idx 4, i.e. R4=30. valid and data must hold 30 for all 20 cycles, and idx 5 follows 3 cycles after the handshake.
- Pulse halted low for one cycle mid-dump at idx 10. The dump must continue uninterrupted, and no second dump may start.
- Assert rst_n low while in SEND at idx 7. All outputs go to 0 immediately. After release, with halted still high, no dump occurs until halted falls and rises again.
- Complete a dump, drop halted, then raise it again. done clears and a second full 32-word dump is produced.
